pixel_write_sink: RTL and testbench

//  Receiving end of the draw-FSM pixel protocol (x, y, color, writeEn, done).

---
 rtl/pixel_write_sink.sv | 168 ++++++++++++++++
 tb/tb_pixel_write_sink.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_sink.sv
// Receiving end of the draw-FSM pixel protocol: clips off-screen pixels, queues the rest and
// drives linear frame-buffer writes under fb_ready backpressure, flagging frame completion.
module pixel_write_sink #(
    parameter int unsigned SCREEN_W = 320,
    parameter int unsigned SCREEN_H = 240,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned COLOR_W  = 12
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [8:0]         in_x_i,
    input  logic [7:0]         in_y_i,
    input  logic [COLOR_W-1:0] in_color_i,
    input  logic               in_we_i,
    input  logic               in_done_i,
    input  logic               fb_ready_i,
    output logic [ADDR_W-1:0]  fb_addr_o,
    output logic [8:0]         fb_x_o,
    output logic [7:0]         fb_y_o,
    output logic [COLOR_W-1:0] fb_color_o,
    output logic               fb_we_o,
    output logic               frame_done_o,
    output logic               busy_o,
    output logic               overflow_o,
    output logic [15:0]        clip_count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0]       FullLvl  = (PtrW + 1)'(DEPTH);
    localparam logic [9:0]          XLim     = 10'(SCREEN_W);
    localparam logic [8:0]          YLim     = 9'(SCREEN_H);
    localparam logic [ADDR_W-1:0]   ScreenWA = ADDR_W'(SCREEN_W);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [8:0]         mem_x_q [DEPTH];
    logic [7:0]         mem_y_q [DEPTH];
    logic [COLOR_W-1:0] mem_c_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   level_q, level_d;

    logic [ADDR_W-1:0]  fb_addr_q;
    logic [8:0]         fb_x_q;
    logic [7:0]         fb_y_q;
    logic [COLOR_W-1:0] fb_color_q;
    logic               fb_we_q;
    logic               overflow_q;
    logic [15:0]        clip_q;

    logic empty, full, in_range, push_req, push, pop;
    logic [8:0]         head_x;
    logic [7:0]         head_y;
    logic [COLOR_W-1:0] head_c;
    logic [ADDR_W-1:0]  head_addr;

    assign empty    = (level_q == '0);
    assign full     = (level_q == FullLvl);
    assign in_range = ({1'b0, in_x_i} < XLim) && ({1'b0, in_y_i} < YLim);
    assign push_req = in_we_i && in_range;
    assign pop      = !empty && (!fb_we_q || fb_ready_i);
    // A full FIFO still accepts a pixel when its head leaves in the same cycle.
    assign push     = push_req && (!full || pop);

    assign head_x    = mem_x_q[rd_ptr_q];
    assign head_y    = mem_y_q[rd_ptr_q];
    assign head_c    = mem_c_q[rd_ptr_q];
    assign head_addr = ADDR_W'(head_y) * ScreenWA + ADDR_W'(head_x);

    always_ff @(posedge clock) begin
        if (push) begin
            mem_x_q[wr_ptr_q] <= in_x_i;
            mem_y_q[wr_ptr_q] <= in_y_i;
            mem_c_q[wr_ptr_q] <= in_color_i;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (PtrW + 1)'(1);
            2'b01:   level_d = level_q - (PtrW + 1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
            clip_q     <= '0;
        end else begin
            if (push_req && !push) overflow_q <= 1'b1;
            if (in_we_i && !in_range && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            fb_addr_q  <= '0;
            fb_x_q     <= '0;
            fb_y_q     <= '0;
            fb_color_q <= '0;
            fb_we_q    <= 1'b0;
        end else if (pop) begin
            fb_addr_q  <= head_addr;
            fb_x_q     <= head_x;
            fb_y_q     <= head_y;
            fb_color_q <= head_c;
            fb_we_q    <= 1'b1;
        end else if (fb_we_q && fb_ready_i) begin
            fb_we_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_done_i)    state_d = StDrain;
                else if (in_we_i) state_d = StStream;
            end
            StStream: begin
                if (in_done_i) state_d = StDrain;
            end
            // A pixel arriving now belongs to the frame and must drain first.
            StDrain: begin
                if (empty && !fb_we_q && !push) state_d = StDone;
            end
            StDone: begin
                if (in_done_i)    state_d = StDrain;
                else if (in_we_i) state_d = StStream;
                else              state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    assign fb_addr_o    = fb_addr_q;
    assign fb_x_o       = fb_x_q;
    assign fb_y_o       = fb_y_q;
    assign fb_color_o   = fb_color_q;
    assign fb_we_o      = fb_we_q;
    assign frame_done_o = (state_q == StDone);
    assign busy_o       = (state_q != StIdle) || !empty || fb_we_q;
    assign overflow_o   = overflow_q;
    assign clip_count_o = clip_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed and randomized bench for pixel_write_sink against a queue-based frame model.
module tb_pixel_write_sink;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [8:0]  in_x = '0;
    logic [7:0]  in_y = '0;
    logic [11:0] in_color = '0;
    logic        in_we = 1'b0;
    logic        in_done = 1'b0;
    logic        fb_ready = 1'b0;
    logic [16:0] fb_addr;
    logic [8:0]  fb_x;
    logic [7:0]  fb_y;
    logic [11:0] fb_color;
    logic        fb_we, frame_done, busy, overflow;
    logic [15:0] clip_count;

    pixel_write_sink dut (
        .clock        (clock),
        .resetn       (resetn),
        .in_x_i       (in_x),
        .in_y_i       (in_y),
        .in_color_i   (in_color),
        .in_we_i      (in_we),
        .in_done_i    (in_done),
        .fb_ready_i   (fb_ready),
        .fb_addr_o    (fb_addr),
        .fb_x_o       (fb_x),
        .fb_y_o       (fb_y),
        .fb_color_o   (fb_color),
        .fb_we_o      (fb_we),
        .frame_done_o (frame_done),
        .busy_o       (busy),
        .overflow_o   (overflow),
        .clip_count_o (clip_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    // Reference: pending pixels, the single write slot, sticky flags and frame phase
    pix_t mq[$];
    int   m_we, m_x, m_y, m_c, m_addr, m_ovf, m_clip;
    int   m_phase;  // 0 idle, 1 drawing, 2 finishing, 3 done pulse
    int   checks = 0;
    int   errors = 0;
    int   n_wr, n_fd;
    int   wr_x[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_we = 0; m_x = 0; m_y = 0; m_c = 0; m_addr = 0;
        m_ovf = 0; m_clip = 0; m_phase = 0;
    endtask

    task automatic model_edge();
        bit   was_empty, was_we, pop, inr, push;
        pix_t p;
        if (!resetn) begin
            model_clear();
            return;
        end
        was_empty = (mq.size() == 0);
        was_we    = (m_we != 0);
        pop  = !was_empty && (!was_we || fb_ready);
        inr  = (int'(in_x) < 320) && (int'(in_y) < 240);
        push = 1'b0;
        if (in_we && !inr && m_clip < 65535) m_clip++;
        if (in_we && inr) begin
            if (mq.size() < 16 || pop) push = 1'b1;
            else m_ovf = 1;
        end
        if (pop) begin
            p = mq.pop_front();
            m_x = p.x; m_y = p.y; m_c = p.c;
            m_addr = p.y * 320 + p.x;
            m_we = 1;
        end else if (was_we && fb_ready) begin
            m_we = 0;
        end
        if (push) begin
            p.x = int'(in_x); p.y = int'(in_y); p.c = int'(in_color);
            mq.push_back(p);
        end
        case (m_phase)
            0: if (in_done) m_phase = 2; else if (in_we) m_phase = 1;
            1: if (in_done) m_phase = 2;
            2: if (was_empty && !was_we && !push) m_phase = 3;
            default: if (in_done) m_phase = 2; else if (in_we) m_phase = 1; else m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        chk("fb_we", 32'(fb_we), 32'(m_we));
        chk("fb_x", 32'(fb_x), 32'(m_x));
        chk("fb_y", 32'(fb_y), 32'(m_y));
        chk("fb_color", 32'(fb_color), 32'(m_c));
        chk("fb_addr", 32'(fb_addr), 32'(m_addr));
        chk("frame_done", 32'(frame_done), 32'(m_phase == 3));
        chk("busy", 32'(busy), 32'(m_phase != 0 || mq.size() != 0 || m_we != 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("clip_count", 32'(clip_count), 32'(m_clip));
    endtask

    // Inputs are already set; log handshakes seen on the DUT, clock once, then check.
    task automatic cycle();
        if (fb_we && fb_ready) begin
            n_wr++;
            wr_x.push_back(int'(fb_x));
        end
        if (frame_done) n_fd++;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic pixel(input int x, input int y, input int c);
        in_we = 1'b1; in_x = 9'(x); in_y = 8'(y); in_color = 12'(c);
        cycle();
        in_we = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0; in_we = 1'b0; in_done = 1'b0;
        cycle();
        resetn = 1'b1;
    endtask

    task automatic clear_obs();
        n_wr = 0; n_fd = 0; wr_x.delete();
    endtask

    initial begin
        model_clear();
        clear_obs();
        resetn = 1'b0;
        cycle();
        cycle();
        chk("reset_we", 32'(fb_we), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        resetn = 1'b1;

        // Single pixel: visible two edges after it is presented, for one cycle
        fb_ready = 1'b1;
        pixel(10, 20, 'hBBB);
        chk("t1_we_early", 32'(fb_we), 32'd0);
        cycle();
        chk("t1_we", 32'(fb_we), 32'd1);
        chk("t1_addr", 32'(fb_addr), 32'd6410);
        chk("t1_color", 32'(fb_color), 32'hBBB);
        cycle();
        chk("t1_we_after", 32'(fb_we), 32'd0);

        // Clipped pixels never reach the frame buffer
        clear_obs();
        pixel(320, 5, 1);
        pixel(5, 240, 2);
        pixel(511, 255, 3);
        for (int i = 0; i < 4; i++) cycle();
        chk("t2_writes", 32'(n_wr), 32'd0);
        chk("t2_clip", 32'(clip_count), 32'd3);
        chk("t2_ovf", 32'(overflow), 32'd0);

        // Overflow: one pixel in the write slot, 16 queued, the 18th lost
        do_reset();
        clear_obs();
        fb_ready = 1'b0;
        for (int i = 1; i <= 18; i++) pixel(i, i, i);
        chk("t3_ovf", 32'(overflow), 32'd1);
        fb_ready = 1'b1;
        for (int i = 0; i < 25; i++) cycle();
        chk("t3_writes", 32'(n_wr), 32'd17);
        chk("t3_first", 32'(wr_x.size() > 0 ? wr_x[0] : -1), 32'd1);
        chk("t3_last", 32'(wr_x.size() > 16 ? wr_x[16] : -1), 32'd17);

        // Five pixels and done under alternating backpressure
        do_reset();
        clear_obs();
        fb_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pixel(100 + i, 7, 'h100 + i);
            fb_ready = ~fb_ready;
        end
        in_done = 1'b1;
        cycle();
        in_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            fb_ready = ~fb_ready;
            cycle();
        end
        chk("t4_writes", 32'(n_wr), 32'd5);
        chk("t4_order", 32'(wr_x.size() == 5 ? wr_x[4] : -1), 32'd104);
        chk("t4_frame_done", 32'(n_fd), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);

        // Done with nothing drawn
        clear_obs();
        in_done = 1'b1;
        cycle();
        in_done = 1'b0;
        chk("t5_fd_edge1", 32'(frame_done), 32'd0);
        cycle();
        chk("t5_fd_edge2", 32'(frame_done), 32'd1);
        cycle();
        chk("t5_fd_edge3", 32'(frame_done), 32'd0);
        chk("t5_writes", 32'(n_wr), 32'd0);

        // Reset while draining discards queued pixels and the pending frame_done
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) pixel(200 + i, 30, i);
        pixel(400, 30, 0);
        in_done = 1'b1;
        cycle();
        in_done = 1'b0;
        do_reset();
        chk("t6_we", 32'(fb_we), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk("t6_clip", 32'(clip_count), 32'd0);
        clear_obs();
        fb_ready = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("t6_writes", 32'(n_wr), 32'd0);
        chk("t6_fd", 32'(n_fd), 32'd0);

        // Randomized traffic in phases of varying backpressure
        for (int ph = 0; ph < 12; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 20 : ((ph % 3 == 1) ? 60 : 100);
            for (int i = 0; i < 250; i++) begin
                resetn   = ($urandom_range(0, 599) != 0);
                in_we    = ($urandom_range(0, 3) != 0);
                in_x     = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(0, 511))
                                                       : 9'($urandom_range(0, 319));
                in_y     = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 239));
                in_color = 12'($urandom);
                in_done  = ($urandom_range(0, 39) == 0);
                fb_ready = ($urandom_range(1, 100) <= rdy_pct);
                cycle();
            end
        end
        resetn = 1'b1; in_we = 1'b0; in_done = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
